// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO whose feeder FSM loads the UART transmitter one byte per txEmpty handshake.
// Define UART_TX_FIFO_STATS_EN to build the txByteCount strobe counter (tied to zero otherwise).
module uart_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  sysClk_i,
    input  logic                  rst_i,
    input  logic [7:0]            wrData_i,
    input  logic                  wrEn_i,
    input  logic                  clrOverflow_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  txEmpty_i,
    output logic [7:0]            dataout_o,
    output logic                  txWrite_o,
    output logic [15:0]           txByteCount_o
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(1 << DEPTH_LOG2);
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, WAIT_ACK = 2'd2;

    logic [7:0] mem_q [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0] state_q, state_d;
    logic [7:0] dataout_q;
    logic full_q, empty_q, overflow_q, tx_write_q;
    logic push, pop;

    always_comb begin
        push    = wrEn_i && !full_q;
        pop     = (state_q == IDLE) && !empty_q && txEmpty_i;
        count_d = count_q + CW'(push) - CW'(pop);
        state_d = (state_q == IDLE) ? (pop ? WRITE : IDLE) :
                  (state_q == WRITE) ? WAIT_ACK :
                  (!txEmpty_i || tmr_q == TMR_LAST) ? IDLE : WAIT_ACK;
        tmr_d   = (state_q == WRITE) ? '0 :
                  (state_q == WAIT_ACK && state_d == WAIT_ACK) ? tmr_q + 1'b1 : tmr_q;
    end

    // Storage needs no reset: occupancy lives entirely in the pointers and count.
    always_ff @(posedge sysClk_i) begin
        if (push) mem_q[wr_ptr_q] <= wrData_i;
    end

    always_ff @(posedge sysClk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_write_q <= 1'b0;
            dataout_q  <= 8'h00;
            state_q    <= IDLE;
            tmr_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop) dataout_q <= mem_q[rd_ptr_q];
            count_q    <= count_d;
            full_q     <= count_d == FULL_CNT;
            empty_q    <= count_d == '0;
            overflow_q <= (wrEn_i && full_q) || (overflow_q && !clrOverflow_i);
            tx_write_q <= pop;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
        end
    end

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] byte_cnt_q;
    always_ff @(posedge sysClk_i or posedge rst_i) begin
        if (rst_i) byte_cnt_q <= 16'h0000;
        else byte_cnt_q <= byte_cnt_q + 16'(pop);
    end
    assign txByteCount_o = byte_cnt_q;
`else
    assign txByteCount_o = 16'h0000;
`endif

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign dataout_o  = dataout_q;
    assign txWrite_o  = tx_write_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_uart_tx_fifo;
    localparam int AT = 15;
`ifdef UART_TX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic wr_en = 1'b0, clr_ovf = 1'b0, tx_empty = 1'b1;
    logic full, empty, overflow, tx_write;
    logic [4:0] count;
    logic [7:0] dataout;
    logic [15:0] tx_byte_count;

    uart_tx_fifo #(.DEPTH_LOG2(4), .ACK_TIMEOUT(AT)) dut (
        .sysClk_i(clk), .rst_i(rst), .wrData_i(wr_data), .wrEn_i(wr_en),
        .clrOverflow_i(clr_ovf), .full_o(full), .empty_o(empty), .count_o(count),
        .overflow_o(overflow), .txEmpty_i(tx_empty), .dataout_o(dataout),
        .txWrite_o(tx_write), .txByteCount_o(tx_byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wr; logic [7:0] data; bit clr; bit txe;
        int e_count; bit e_full; bit e_empty; bit e_ovf; bit e_txw; logic [7:0] e_dout;
    } vec_t;
    vec_t vecs[24];

    int checks = 0, errors = 0;
    int cyc_n, s_last, total, busy, busy_len = 10, b2b, pushed;
    bit in_wait, m_ovf, m_txw, tx_mode, prev_txw;
    logic [7:0] m_dout;
    logic [7:0] mq[$];
    logic [7:0] got[$];
    int strobe_t[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cyc_n = 0; s_last = 0; total = 0;
        in_wait = 0; m_ovf = 0; m_txw = 0; m_dout = 8'h00;
    endtask

    // Timeline model: a strobe in cycle s is followed by up to AT waiting cycles,
    // cut short by the first cycle in which the transmitter reports busy.
    task automatic model_edge();
        bit pop;
        int pre;
        pop = 0;
        pre = mq.size();
        if (in_wait) begin
            if (!tx_empty || cyc_n == s_last + AT) in_wait = 0;
        end else if (m_txw) in_wait = 1;
        else if (pre > 0 && tx_empty) pop = 1;
        if (pop) begin
            m_dout = mq.pop_front();
            total++;
            s_last = cyc_n + 1;
        end
        m_txw = pop;
        if (wr_en && pre < 16) mq.push_back(wr_data);
        if (wr_en && pre == 16) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        cyc_n++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_edge();
        check("count", int'(count), mq.size());
        check("full", int'(full), int'(mq.size() == 16));
        check("empty", int'(empty), int'(mq.size() == 0));
        check("overflow", int'(overflow), int'(m_ovf));
        check("txWrite", int'(tx_write), int'(m_txw));
        check("dataout", int'(dataout), int'(m_dout));
        check("txByteCount", int'(tx_byte_count), STATS ? total % 65536 : 0);
        if (tx_write && prev_txw) b2b++;
        prev_txw = tx_write;
        if (tx_write) begin
            strobe_t.push_back(cyc_n);
            got.push_back(dataout);
        end
        if (tx_mode) begin
            if (busy > 0) begin
                tx_empty = 1'b0;
                busy--;
            end else tx_empty = 1'b1;
            if (tx_write) busy = busy_len;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; clr_ovf = 1'b0;
        tx_mode = 0; busy = 0; prev_txw = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        vecs[0] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00};
        vecs[1] = '{1, 8'hA5, 0, 1, 1, 0, 0, 0, 0, 8'h00};
        vecs[2] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 8'hA5};
        vecs[3] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'hA5};
        for (int i = 0; i < 16; i++)
            vecs[4 + i] = '{1, 8'(i), 0, 0, i + 1, i == 15, 0, 0, 0, 8'hA5};
        vecs[20] = '{1, 8'h10, 0, 0, 16, 1, 0, 1, 0, 8'hA5};
        vecs[21] = '{0, 8'h00, 1, 0, 16, 1, 0, 0, 0, 8'hA5};
        vecs[22] = '{1, 8'h11, 1, 0, 16, 1, 0, 1, 0, 8'hA5};
        vecs[23] = '{0, 8'h00, 1, 0, 16, 1, 0, 0, 0, 8'hA5};

        do_reset();
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_txWrite", int'(tx_write), 0);
        check("rst_dataout", int'(dataout), 0);
        check("rst_txByteCount", int'(tx_byte_count), 0);

        tx_empty = 1'b1;
        for (int i = 0; i < 24; i++) begin
            wr_en = vecs[i].wr; wr_data = vecs[i].data;
            clr_ovf = vecs[i].clr; tx_empty = vecs[i].txe;
            cyc();
            check("vec_count", int'(count), vecs[i].e_count);
            check("vec_full", int'(full), int'(vecs[i].e_full));
            check("vec_empty", int'(empty), int'(vecs[i].e_empty));
            check("vec_overflow", int'(overflow), int'(vecs[i].e_ovf));
            check("vec_txWrite", int'(tx_write), int'(vecs[i].e_txw));
            check("vec_dataout", int'(dataout), int'(vecs[i].e_dout));
        end

        wr_en = 1'b0; clr_ovf = 1'b0;
        got.delete(); b2b = 0; busy_len = 10; busy = 0; tx_mode = 1;
        repeat (300) cyc();
        check("drain_pulses", got.size(), 16);
        for (int i = 0; i < got.size(); i++) check("drain_order", int'(got[i]), i);
        check("drain_back_to_back", b2b, 0);

        do_reset();
        tx_empty = 1'b1;
        strobe_t.delete();
        wr_en = 1'b1; wr_data = 8'h31; cyc();
        wr_data = 8'h32; cyc();
        wr_en = 1'b0;
        repeat (60) cyc();
        check("timeout_pulses", strobe_t.size(), 2);
        if (strobe_t.size() == 2) begin
            check("first_strobe_cycle", strobe_t[0], 2);
            check("timeout_gap", strobe_t[1] - strobe_t[0], AT + 2);
        end

        do_reset();
        tx_empty = 1'b0;
        got.delete();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i); cyc();
        end
        check("pre_pushpop_count", int'(count), 5);
        wr_data = 8'h15; tx_empty = 1'b1; cyc();
        check("pushpop_count", int'(count), 5);
        check("pushpop_txWrite", int'(tx_write), 1);
        wr_en = 1'b0; busy_len = 10; busy = 0; tx_mode = 1; pushed = 0;
        for (int k = 0; k < 1500 && (pushed < 20 || mq.size() > 0); k++) begin
            wr_en = pushed < 20 && mq.size() < 16;
            wr_data = 8'(8'h16 + pushed);
            if (wr_en) pushed++;
            cyc();
        end
        wr_en = 1'b0;
        check("wrap_drained", int'(count), 0);
        check("wrap_pulses", got.size(), 26);
        for (int i = 0; i < got.size(); i++) check("wrap_order", int'(got[i]), 8'h10 + i);

        do_reset();
        for (int k = 0; k < 800; k++) begin
            wr_en = $urandom_range(0, 2) != 0;
            wr_data = 8'($urandom);
            clr_ovf = $urandom_range(0, 15) == 0;
            tx_empty = $urandom_range(0, 3) != 0;
            cyc();
        end
        wr_en = 1'b0; clr_ovf = 1'b0;

        do_reset();
        tx_empty = 1'b1;
        wr_en = 1'b1; wr_data = 8'h55; cyc();
        wr_data = 8'h66; cyc();
        wr_en = 1'b0;
        check("write_state_txWrite", int'(tx_write), 1);
        check("write_state_count", int'(count), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_txWrite", int'(tx_write), 0);
        check("async_rst_count", int'(count), 0);
        check("async_rst_empty", int'(empty), 1);

        do_reset();
        busy_len = 1; busy = 0; tx_mode = 1; pushed = 0;
        for (int k = 0; k < 6000 && (pushed < 300 || mq.size() > 0); k++) begin
            wr_en = pushed < 300 && mq.size() < 16;
            wr_data = 8'($urandom);
            if (wr_en) pushed++;
            cyc();
        end
        wr_en = 1'b0;
        repeat (3) cyc();
        check("bytes_sent_300", int'(tx_byte_count), STATS ? 300 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
